// File: rtl/traffic_scheduler_if.sv
// Bundle of the per-pixel render path and frame-update handshake between the
// video timing logic (master) and the road-lane scheduler (slave).
interface traffic_scheduler_if;
   logic       i_Enable;
   logic       i_Frame_Start;
   logic [9:0] i_H_Pos;
   logic [9:0] i_V_Pos;
   logic       o_Car_Hit;
   logic [2:0] o_Red;
   logic [2:0] o_Green;
   logic [2:0] o_Blue;
   logic       o_Busy;
   logic       o_Update_Done;
   logic       o_Overrun;

   modport master (
      output i_Enable, i_Frame_Start, i_H_Pos, i_V_Pos,
      input  o_Car_Hit, o_Red, o_Green, o_Blue, o_Busy, o_Update_Done, o_Overrun
   );

   modport slave (
      input  i_Enable, i_Frame_Start, i_H_Pos, i_V_Pos,
      output o_Car_Hit, o_Red, o_Green, o_Blue, o_Busy, o_Update_Done, o_Overrun
   );
endinterface

// File: rtl/traffic_scheduler.sv
// Road-lane car motion controller and pixel arbiter: advances one lane per cycle
// through a shared datapath after each frame start and renders the car layer.
module traffic_scheduler #(
   parameter int NUM_LANES  = 4,
   parameter int CAR_WIDTH  = 32,
   parameter int CAR_HEIGHT = 32,
   parameter int SCREEN_W   = 640,
   parameter int LANE_Y0    = 96,
   parameter int LANE_PITCH = 64
) (
   input logic i_Clk,
   input logic i_Reset,
   traffic_scheduler_if.slave bus
);

   localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [9:0]       X_MAX    = 10'(SCREEN_W - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

   typedef enum logic [1:0] {
      IDLE,
      UPDATE,
      DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] lane_idx;
   logic [IDX_W-1:0] next_lane_idx;
   logic             lane_write;
   logic             busy;
   logic             update_done;
   logic             overrun;

   logic [9:0]       car_x   [NUM_LANES];
   logic [2:0]       car_div [NUM_LANES];
   logic [9:0]       cur_x;
   logic [2:0]       cur_div;
   logic [9:0]       upd_x;
   logic [2:0]       upd_div;

   logic [10:0]      h_ext;
   logic [10:0]      v_ext;
   logic [10:0]      lane_x;
   logic [10:0]      lane_y;
   logic             hit_any;
   logic [2:0]       hit_lane;
   logic             car_hit_q;
   logic [8:0]       colour_q;

   function automatic logic [8:0] lane_colour(input logic [2:0] lane);
      case (lane)
         3'd0:    lane_colour = 9'b111_000_000;
         3'd1:    lane_colour = 9'b000_111_000;
         3'd2:    lane_colour = 9'b000_000_111;
         3'd3:    lane_colour = 9'b111_111_000;
         default: lane_colour = 9'b111_111_111;
      endcase
   endfunction

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state    <= IDLE;
         lane_idx <= '0;
      end else begin
         state    <= next_state;
         lane_idx <= next_lane_idx;
      end
   end

   // A frame start is only honoured from IDLE, so a pulse during a sequence never restarts it.
   always_comb begin
      next_state    = state;
      next_lane_idx = lane_idx;
      lane_write    = 1'b0;
      busy          = 1'b0;
      update_done   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_Frame_Start && bus.i_Enable) begin
               next_state    = UPDATE;
               next_lane_idx = '0;
            end
         end
         UPDATE: begin
            busy       = 1'b1;
            lane_write = 1'b1;
            if (lane_idx == LAST_IDX) begin
               next_state = DONE;
            end else begin
               next_lane_idx = lane_idx + IDX_W'(1);
            end
         end
         DONE: begin
            busy        = 1'b1;
            update_done = 1'b1;
            next_state  = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Shared update datapath: lane k moves once every k+1 frames, even lanes right, odd left.
   always_comb begin
      cur_x   = '0;
      cur_div = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (IDX_W'(k) == lane_idx) begin
            cur_x   = car_x[k];
            cur_div = car_div[k];
         end
      end
      upd_x   = cur_x;
      upd_div = cur_div + 3'd1;
      if (cur_div == 3'(lane_idx)) begin
         upd_div = '0;
         if (!lane_idx[0]) begin
            upd_x = (cur_x == X_MAX) ? 10'd0 : cur_x + 10'd1;
         end else begin
            upd_x = (cur_x == 10'd0) ? X_MAX : cur_x - 10'd1;
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            car_x[k]   <= 10'(k * 128);
            car_div[k] <= '0;
         end
      end else if (lane_write) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (IDX_W'(k) == lane_idx) begin
               car_x[k]   <= upd_x;
               car_div[k] <= upd_div;
            end
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         overrun <= 1'b0;
      end else if (bus.i_Frame_Start && busy) begin
         overrun <= 1'b1;
      end
   end

   // Scanning from the highest lane down lets the lowest hitting lane win; 11-bit sums avoid overflow.
   always_comb begin
      h_ext    = {1'b0, bus.i_H_Pos};
      v_ext    = {1'b0, bus.i_V_Pos};
      lane_x   = '0;
      lane_y   = '0;
      hit_any  = 1'b0;
      hit_lane = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         lane_x = {1'b0, car_x[k]};
         lane_y = 11'(LANE_Y0 + k * LANE_PITCH);
         if ((h_ext >= lane_x) && (h_ext < lane_x + 11'(CAR_WIDTH)) &&
             (v_ext >= lane_y) && (v_ext < lane_y + 11'(CAR_HEIGHT))) begin
            hit_any  = 1'b1;
            hit_lane = 3'(k);
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         car_hit_q <= 1'b0;
         colour_q  <= '0;
      end else begin
         car_hit_q <= hit_any;
         colour_q  <= hit_any ? lane_colour(hit_lane) : 9'd0;
      end
   end

   assign bus.o_Car_Hit     = car_hit_q;
   assign bus.o_Red         = colour_q[8:6];
   assign bus.o_Green       = colour_q[5:3];
   assign bus.o_Blue        = colour_q[2:0];
   assign bus.o_Busy        = busy;
   assign bus.o_Update_Done = update_done;
   assign bus.o_Overrun     = overrun;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Randomized bench for traffic_scheduler: two instances (lane pitch 64 and 16)
// share stimulus and are checked against a closed-form model of car motion and rendering.
module tb_traffic_scheduler;

   localparam int NUM_LANES = 4;

   logic i_Clk = 1'b0;
   logic i_Reset;

   always #20 i_Clk = ~i_Clk;

   traffic_scheduler_if ifA ();
   traffic_scheduler_if ifB ();

   traffic_scheduler #(
      .NUM_LANES(NUM_LANES), .CAR_WIDTH(32), .CAR_HEIGHT(32),
      .SCREEN_W(640), .LANE_Y0(96), .LANE_PITCH(64)
   ) dutA (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .bus(ifA.slave)
   );

   traffic_scheduler #(
      .NUM_LANES(NUM_LANES), .CAR_WIDTH(32), .CAR_HEIGHT(32),
      .SCREEN_W(640), .LANE_Y0(96), .LANE_PITCH(16)
   ) dutB (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .bus(ifB.slave)
   );

   int checkCount = 0;
   int errorCount = 0;
   int frames = 0;
   logic [9:0] curH = '0;
   logic [9:0] curV = '0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic fs, input logic [9:0] h, input logic [9:0] v);
      curH = h;
      curV = v;
      ifA.i_Enable = en;  ifA.i_Frame_Start = fs;  ifA.i_H_Pos = h;  ifA.i_V_Pos = v;
      ifB.i_Enable = en;  ifB.i_Frame_Start = fs;  ifB.i_H_Pos = h;  ifB.i_V_Pos = v;
   endtask

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   // Lane k has moved floor(frames/(k+1)) steps from k*128, modulo the screen width.
   function automatic int modelX(input int k);
      int moves;
      moves = frames / (k + 1);
      if (k % 2 == 0) modelX = (k * 128 + moves) % 640;
      else            modelX = (((k * 128 - moves) % 640) + 640) % 640;
   endfunction

   function automatic int modelDiv(input int k);
      modelDiv = frames % (k + 1);
   endfunction

   function automatic int modelRender(input int pitch, input int h, input int v);
      int x, y;
      modelRender = -1;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         x = modelX(k);
         y = 96 + k * pitch;
         if (h >= x && h < x + 32 && v >= y && v < y + 32) modelRender = k;
      end
   endfunction

   function automatic logic [8:0] modelColour(input int lane);
      case (lane)
         0:       modelColour = 9'b111_000_000;
         1:       modelColour = 9'b000_111_000;
         2:       modelColour = 9'b000_000_111;
         3:       modelColour = 9'b111_111_000;
         -1:      modelColour = 9'b000_000_000;
         default: modelColour = 9'b111_111_111;
      endcase
   endfunction

   task automatic checkRender();
      int laneA, laneB;
      laneA = modelRender(64, int'(curH), int'(curV));
      laneB = modelRender(16, int'(curH), int'(curV));
      checkOutput("hitA", 32'(ifA.o_Car_Hit), 32'(laneA >= 0));
      checkOutput("rgbA", 32'({ifA.o_Red, ifA.o_Green, ifA.o_Blue}), 32'(modelColour(laneA)));
      checkOutput("hitB", 32'(ifB.o_Car_Hit), 32'(laneB >= 0));
      checkOutput("rgbB", 32'({ifB.o_Red, ifB.o_Green, ifB.o_Blue}), 32'(modelColour(laneB)));
   endtask

   task automatic checkLanes(input logic withDiv);
      for (int k = 0; k < NUM_LANES; k++) begin
         checkOutput($sformatf("x%0d_f%0d", k, frames), 32'(dutA.car_x[k]), 32'(modelX(k)));
         if (withDiv) checkOutput($sformatf("div%0d", k), 32'(dutA.car_div[k]), 32'(modelDiv(k)));
      end
   endtask

   // Pulses frame start in cycle 0, then watches cycles 1..12 counting busy/done.
   task automatic runFrame(input logic en, input int extraAt, input logic randMid,
                           output int busyCnt, output int doneAt, output int doneCnt);
      logic midEn;
      busyCnt = 0;
      doneAt  = -1;
      doneCnt = 0;
      applyStimulus(en, 1'b1, curH, curV);
      tick();
      for (int c = 1; c <= 12; c++) begin
         if (ifA.o_Busy) busyCnt++;
         if (ifA.o_Update_Done) begin
            doneCnt++;
            doneAt = c;
         end
         midEn = randMid ? 1'($urandom_range(0, 1)) : en;
         applyStimulus(midEn, c == extraAt, curH, curV);
         tick();
      end
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int busyCnt, doneAt, doneCnt;
      int h, v, k, x0, x1;
      logic en;

      i_Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 10'd0, 10'd0);
      #5;
      checkOutput("rst_busy", 32'(ifA.o_Busy), 32'd0);
      checkOutput("rst_done", 32'(ifA.o_Update_Done), 32'd0);
      checkOutput("rst_ovr", 32'(ifA.o_Overrun), 32'd0);
      checkOutput("rst_hit", 32'(ifA.o_Car_Hit), 32'd0);
      checkLanes(1'b1);
      tick();
      tick();
      i_Reset = 1'b0;
      tick();

      applyStimulus(1'b0, 1'b0, 10'd0, 10'd96);
      tick();
      checkOutput("render_h0_hit", 32'(ifA.o_Car_Hit), 32'd1);
      checkOutput("render_h0_rgb", 32'({ifA.o_Red, ifA.o_Green, ifA.o_Blue}), 32'h1C0);
      applyStimulus(1'b0, 1'b0, 10'd32, 10'd96);
      tick();
      checkOutput("render_h32_hit", 32'(ifA.o_Car_Hit), 32'd0);
      checkOutput("render_h32_rgb", 32'({ifA.o_Red, ifA.o_Green, ifA.o_Blue}), 32'd0);

      runFrame(1'b1, 0, 1'b0, busyCnt, doneAt, doneCnt);
      frames++;
      checkOutput("one_busy", 32'(busyCnt), 32'(NUM_LANES + 1));
      checkOutput("one_doneAt", 32'(doneAt), 32'(NUM_LANES + 1));
      checkOutput("one_doneCnt", 32'(doneCnt), 32'd1);
      checkOutput("one_x0", 32'(dutA.car_x[0]), 32'd1);
      checkLanes(1'b1);

      for (int f = 0; f < 5; f++) begin
         runFrame(1'b1, 0, 1'b0, busyCnt, doneAt, doneCnt);
         frames++;
      end
      checkOutput("six_x0", 32'(dutA.car_x[0]), 32'd6);
      checkOutput("six_x1", 32'(dutA.car_x[1]), 32'd125);
      checkOutput("six_x2", 32'(dutA.car_x[2]), 32'd258);
      checkOutput("six_x3", 32'(dutA.car_x[3]), 32'd383);

      runFrame(1'b0, 0, 1'b0, busyCnt, doneAt, doneCnt);
      checkOutput("frz_busy", 32'(busyCnt), 32'd0);
      checkOutput("frz_ovr", 32'(ifA.o_Overrun), 32'd0);
      checkLanes(1'b1);

      runFrame(1'b1, 2, 1'b0, busyCnt, doneAt, doneCnt);
      frames++;
      checkOutput("ovr_busy", 32'(busyCnt), 32'(NUM_LANES + 1));
      checkOutput("ovr_doneAt", 32'(doneAt), 32'(NUM_LANES + 1));
      checkOutput("ovr_flag", 32'(ifA.o_Overrun), 32'd1);
      checkLanes(1'b1);

      applyStimulus(1'b1, 1'b1, 10'd0, 10'd96);
      tick();
      applyStimulus(1'b1, 1'b0, 10'd0, 10'd96);
      tick();
      i_Reset = 1'b1;
      frames = 0;
      #2;
      checkOutput("mid_rst_busy", 32'(ifA.o_Busy), 32'd0);
      checkOutput("mid_rst_ovr", 32'(ifA.o_Overrun), 32'd0);
      checkOutput("mid_rst_hit", 32'(ifA.o_Car_Hit), 32'd0);
      checkLanes(1'b1);
      tick();
      i_Reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 10'd700, 10'd0);
      tick();
      tick();
      tick();
      checkOutput("post_rst_busy", 32'(ifA.o_Busy), 32'd0);
      checkLanes(1'b1);

      for (int it = 0; it < 1000 && frames < 660; it++) begin
         en = ($urandom_range(0, 7) != 0);
         runFrame(en, 0, 1'b1, busyCnt, doneAt, doneCnt);
         if (en) frames++;
         checkOutput("rnd_busy", 32'(busyCnt), en ? 32'(NUM_LANES + 1) : 32'd0);
         checkOutput("rnd_done", 32'(doneCnt), en ? 32'd1 : 32'd0);
         checkLanes(1'b0);
         if (it % 3 == 0) begin
            k = int'($urandom_range(0, NUM_LANES - 1));
            h = modelX(k) + int'($urandom_range(0, 40)) - 4;
            v = 96 + k * 64 + int'($urandom_range(0, 40)) - 4;
            if (h < 0) h = 0;
            applyStimulus(1'b1, 1'b0, 10'(h), 10'(v));
            tick();
            checkRender();
         end
         x0 = modelX(0);
         x1 = modelX(1);
         if (x0 < x1 + 32 && x1 < x0 + 32) begin
            applyStimulus(1'b1, 1'b0, 10'((x0 > x1) ? x0 : x1), 10'd115);
            tick();
            checkOutput("ovl_hitB", 32'(ifB.o_Car_Hit), 32'd1);
            checkOutput("ovl_rgbB", 32'({ifB.o_Red, ifB.o_Green, ifB.o_Blue}), 32'h1C0);
         end
      end
      checkOutput("final_ovr", 32'(ifA.o_Overrun), 32'd0);
      checkLanes(1'b1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

Per-frame motion controller and pixel arbiter for the road lanes of the Frogger playfield. It owns the x position of one car per lane and advances every lane once per video frame through a single shared update datapath. It resolves which car, if any, covers the current VGA pixel and drives the road-layer colour into the pixel mux, ahead of the frog sprite.

## Interface
- NUM_LANES, 4: lanes/cars managed; legal 1..8
- CAR_WIDTH, 32: car width in pixels
- CAR_HEIGHT, 32: car height in pixels
- SCREEN_W, 640: visible width; legal x range is 0..SCREEN_W-1
- LANE_Y0, 96: top row of lane 0
- LANE_PITCH, 64: vertical distance between lane tops

- i_Clk  in  1  pixel clock (25 MHz); single clock domain
- i_Reset  in  1  asynchronous, active-high reset
- i_Enable  in  1  1 = motion allowed; 0 = freeze (rendering continues)
- i_Frame_Start  in  1  one-cycle pulse at start of vertical blank
- i_H_Pos  in  10  current pixel column
- i_V_Pos  in  10  current pixel row
- o_Car_Hit  out  1  current pixel belongs to a car
- o_Red, o_Green, o_Blue  out  3 each  car colour; 000 when no hit
- o_Busy  out  1  update sequence in progress
- o_Update_Done  out  1  one-cycle pulse when all lanes are updated
- o_Overrun  out  1  sticky: frame start arrived while busy

## Operation
- Per-lane state: x[k] (10 bits), div[k] (3 bits). Lane y is LANE_Y0 + k*LANE_PITCH.
- Reset values: x[k] = k*128, div[k] = 0, FSM = IDLE, all outputs 0.
- FSM states:
  - IDLE: if i_Frame_Start && i_Enable, go to UPDATE with lane index 0. Otherwise stay in IDLE.
  - UPDATE: process lane idx, one lane per cycle, through one shared adder/comparator. After lane NUM_LANES-1, go to DONE.
  - DONE: assert o_Update_Done for one cycle, then go to IDLE.
- Lane update:
  - If div[k] == k: move the car and clear div[k]. Otherwise increment div[k].
  - Lane k therefore moves once every k+1 frames.
- Direction: even lanes move right, odd lanes move left.
- Wrap-around:
  - Right: x = SCREEN_W-1 becomes 0; otherwise x+1.
  - Left: x = 0 becomes SCREEN_W-1; otherwise x-1.
- Rendering (independent of the FSM):
  - Lane k hits when x[k] <= h < x[k]+CAR_WIDTH and y_k <= v < y_k+CAR_HEIGHT.
  - Sums are computed 11 bits wide, so there is no 10-bit overflow.
  - Cars are clipped at the right edge and do not wrap visually.
- Priority: when several lanes hit, the lowest lane index wins.
- Colours:
  - Lane 0: red 111/000/000
  - Lane 1: green 000/111/000
  - Lane 2: blue 000/000/111
  - Lane 3: yellow 111/111/000
  - Lanes 4–7: white 111/111/111
- Frame start while o_Busy = 1:
  - The pulse is ignored and the sequence is not restarted.
  - o_Overrun is set and stays set until reset.
- i_Enable = 0 at a frame start: no sequence starts, x and div are unchanged, no overrun is flagged.
- i_Enable falling mid-sequence: the sequence completes normally. Enable is checked only at start.
- Reset asserted mid-sequence: all state and outputs return to reset values immediately. No partial-update state survives.

## Timing
- i_Frame_Start is sampled in cycle 0. UPDATE of lane k occurs in cycle 1+k.
- The new x[k] is visible from cycle 2+k.
- o_Update_Done is high in cycle NUM_LANES+1. With 4 lanes, o_Busy is high for 5 cycles, i.e. cycles 1..NUM_LANES+1.
- Render path is registered with 1-cycle latency: o_Car_Hit and colours for (h,v) presented in cycle n appear in cycle n+1.
- During update cycles, rendering uses the x register value at that cycle. The update runs in vertical blank, so no tearing is visible.

## Test plan
- **Reset:** pulse i_Reset mid-UPDATE.
  - Outputs 0 and x = {0,128,256,384} asynchronously.
  - After release, x is unchanged with no frame start.
- **One frame:** i_Enable=1, single i_Frame_Start.
  - After o_Update_Done: x = {1,128,256,384}, div = {0,1,1,1}.
  - o_Busy high exactly 5 cycles; o_Update_Done in cycle 5.
- **Periods:** 6 frames from reset.
  - x0 = 6, x1 = 125, x2 = 258, x3 = 383.
- **Wrap:** force lane 0 to x=639, one frame → x0 = 0. Force lane 1 to x=0, two frames → x1 = 639.
- **Render/priority:**
  - After reset, h=0, v=96 → next cycle hit=1, colour 111/000/000.
  - h=32, v=96 → hit=0, colour 000.
  - With lanes 0 and 1 overlapping (set LANE_PITCH=16), an overlap pixel → red.
- **Overrun/freeze:**
  - i_Frame_Start at busy cycle 2 → o_Overrun=1, sequence still completes after exactly 4 lane updates.
  - i_Enable=0 with a frame start → no o_Busy, x unchanged.
